// File: rtl/sprite_spawner_if.sv
// Spawn request and sprite offset bundle between a sprite layer and its spawner.
// The requester is the master; the spawner drives the offsets and status.
interface sprite_spawner_if #(
   parameter int HWIDTH = 12,
   parameter int VWIDTH = 12
);
   logic              en;
   logic [HWIDTH-1:0] hoffset;
   logic [VWIDTH-1:0] voffset;
   logic              busy;
   logic              done;

   modport master (
      output en,
      input  hoffset,
      input  voffset,
      input  busy,
      input  done
   );

   modport slave (
      input  en,
      output hoffset,
      output voffset,
      output busy,
      output done
   );
endinterface

// File: rtl/sprite_spawner.sv
// Linear sprite sweep from (HSRC,VSRC) to (HDST,VDST) over STEP ticks.
// Define SPAWN_LFSR_EN to gate spawn requests with a 20-bit LFSR.
module sprite_spawner #(
   parameter int HWIDTH = 12,
   parameter int VWIDTH = 12,
   parameter int HSRC   = -80,
   parameter int VSRC   = -140,
   parameter int HDST   = -120,
   parameter int VDST   = 220,
   parameter int STEP   = 32
) (
   input logic             clk,
   input logic             rst_n,
   sprite_spawner_if.slave bus
);
   localparam int SH = $clog2(STEP);
   localparam int KW = SH + 1;
   localparam int MW = (HWIDTH > VWIDTH) ? HWIDTH : VWIDTH;
   localparam int IW = MW + SH + 2;

   localparam logic signed [IW-1:0] HS = IW'(HSRC);
   localparam logic signed [IW-1:0] VS = IW'(VSRC);
   localparam logic signed [IW-1:0] HD = IW'(HDST) - HS;
   localparam logic signed [IW-1:0] VD = IW'(VDST) - VS;

   localparam logic [HWIDTH-1:0] H0 = HWIDTH'(HSRC);
   localparam logic [VWIDTH-1:0] V0 = VWIDTH'(VSRC);

   typedef enum logic {
      IDLE,
      MOVE
   } state_t;

   state_t            state, state_n;
   logic [KW-1:0]     k, k_n, kn;
   logic [HWIDTH-1:0] hoff, hoff_n;
   logic [VWIDTH-1:0] voff, voff_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   logic              accept;

   logic signed [IW-1:0] hprod, vprod;

`ifdef SPAWN_LFSR_EN
   logic [19:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 20'hA5A5A;
      else        lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
   end

   assign accept = bus.en & (lfsr[2:0] == 3'b111);
`else
   assign accept = bus.en;
`endif

   // floor((DST-SRC)*k/STEP) via arithmetic shift; IW leaves headroom
   assign kn    = k + KW'(1);
   assign hprod = HD * $signed(IW'(kn));
   assign vprod = VD * $signed(IW'(kn));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         k      <= '0;
         hoff   <= H0;
         voff   <= V0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         k      <= k_n;
         hoff   <= hoff_n;
         voff   <= voff_n;
         busy_q <= busy_n;
         done_q <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      hoff_n  = H0;
      voff_n  = V0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_n = MOVE;
               k_n     = '0;
               busy_n  = 1'b1;
            end
         end
         MOVE: begin
            if (k == KW'(STEP)) begin
               state_n = IDLE;
               k_n     = '0;
            end else begin
               k_n    = kn;
               hoff_n = HWIDTH'(HS + (hprod >>> SH));
               voff_n = VWIDTH'(VS + (vprod >>> SH));
               busy_n = 1'b1;
               done_n = (kn == KW'(STEP));
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.hoffset = hoff;
   assign bus.voffset = voff;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_sprite_spawner.sv
// Randomized and directed bench for sprite_spawner against a
// trajectory model built from floor division on integers.
module tb_sprite_spawner;
   localparam int HW   = 12;
   localparam int VW   = 12;
   localparam int HSRC = -80;
   localparam int VSRC = -140;
   localparam int HDST = -120;
   localparam int VDST = 220;
   localparam int STEP = 32;
   localparam int OW   = HW + VW + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sprite_spawner_if #(.HWIDTH(HW), .VWIDTH(VW)) bus();

   sprite_spawner #(
      .HWIDTH(HW), .VWIDTH(VW),
      .HSRC(HSRC), .VSRC(VSRC),
      .HDST(HDST), .VDST(VDST),
      .STEP(STEP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // ph: -1 when idle, else ticks since the sweep began (0..STEP)
   int          ph = -1;
   logic [19:0] lf = 20'hA5A5A;

   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   function automatic logic [OW-1:0] expv();
      int kk, h, v;
      kk = (ph < 0) ? 0 : ph;
      h = HSRC + fdiv((HDST - HSRC) * kk, STEP);
      v = VSRC + fdiv((VDST - VSRC) * kk, STEP);
      return {HW'(h), VW'(v), ph >= 0, ph == STEP};
   endfunction

   function automatic logic [OW-1:0] obs();
      return {bus.hoffset, bus.voffset, bus.busy, bus.done};
   endfunction

   task automatic model_reset();
      ph = -1;
      lf = 20'hA5A5A;
   endtask

   task automatic step(input logic e);
      logic acc;
      @(negedge clk);
      bus.en = e;
      @(posedge clk);
      acc = e;
`ifdef SPAWN_LFSR_EN
      acc = e && (lf[2:0] == 3'b111);
      lf  = {lf[18:0], lf[19] ^ lf[16]};
`endif
      if (ph < 0) begin
         if (acc) ph = 0;
      end else if (ph == STEP) begin
         ph = -1;
      end else begin
         ph = ph + 1;
      end
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      bus.en = 1'b0;
      model_reset();
      #12;
      total++;
      if (bus.hoffset !== 12'hFB0) begin
         bad++;
         $display("FAIL reset_h got=%h exp=%h", bus.hoffset, 12'hFB0);
      end
      total++;
      if (bus.voffset !== 12'hF74) begin
         bad++;
         $display("FAIL reset_v got=%h exp=%h", bus.voffset, 12'hF74);
      end
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=00", {bus.busy, bus.done});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      step(1'b1);
      total++;
      if (obs() !== {12'hFB0, 12'hF74, 2'b10}) begin
         bad++;
         $display("FAIL single_k0 got=%h exp=%h", obs(), {12'hFB0, 12'hF74, 2'b10});
      end
      step(1'b0);
      total++;
      if ({bus.hoffset, bus.voffset} !== {HW'(-82), VW'(-129)}) begin
         bad++;
         $display("FAIL single_k1 got=%h exp=%h", {bus.hoffset, bus.voffset}, {HW'(-82), VW'(-129)});
      end
      for (int i = 2; i <= 16; i++) step(1'b0);
      total++;
      if ({bus.hoffset, bus.voffset} !== {HW'(-100), VW'(40)}) begin
         bad++;
         $display("FAIL single_k16 got=%h exp=%h", {bus.hoffset, bus.voffset}, {HW'(-100), VW'(40)});
      end
      for (int i = 17; i <= 32; i++) step(1'b0);
      total++;
      if (obs() !== {HW'(-120), VW'(220), 2'b11}) begin
         bad++;
         $display("FAIL single_k32 got=%h exp=%h", obs(), {HW'(-120), VW'(220), 2'b11});
      end
      step(1'b0);
      total++;
      if (obs() !== {12'hFB0, 12'hF74, 2'b00}) begin
         bad++;
         $display("FAIL single_end got=%h exp=%h", obs(), {12'hFB0, 12'hF74, 2'b00});
      end
   endtask

   task automatic test_held();
      int dut_dones, mdl_dones, last;
      dut_dones = 0;
      mdl_dones = 0;
      last = -1;
      for (int t = 0; t < 100; t++) begin
         step(1'b1);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL held_t%0d got=%h exp=%h", t, obs(), expv());
         end
         if (ph == STEP) mdl_dones++;
         if (bus.done === 1'b1) begin
            dut_dones++;
            if (last >= 0) begin
               total++;
               if (t - last !== STEP + 2) begin
                  bad++;
                  $display("FAIL held_period got=%0d exp=%0d", t - last, STEP + 2);
               end
            end
            last = t;
         end
      end
      total++;
      if (dut_dones !== mdl_dones) begin
         bad++;
         $display("FAIL held_dones got=%0d exp=%0d", dut_dones, mdl_dones);
      end
      for (int t = 0; t < STEP + 2; t++) step(1'b0);
   endtask

   task automatic test_ignore_en();
      int t_done;
      t_done = -1;
      step(1'b1);
      for (int t = 1; t <= STEP + 1; t++) begin
         step(t == 10);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL ign_t%0d got=%h exp=%h", t, obs(), expv());
         end
         if (bus.done === 1'b1) t_done = t;
      end
      total++;
      if (t_done !== STEP) begin
         bad++;
         $display("FAIL ign_done_tick got=%0d exp=%0d", t_done, STEP);
      end
      step(1'b0);
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      step(1'b1);
      for (int t = 1; t <= 20; t++) step(1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      total++;
      if (obs() !== {12'hFB0, 12'hF74, 2'b00}) begin
         bad++;
         $display("FAIL rstmid got=%h exp=%h", obs(), {12'hFB0, 12'hF74, 2'b00});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < STEP + 4; t++) begin
         step(1'b0);
         if (bus.done === 1'b1) dones++;
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL rstmid_t%0d got=%h exp=%h", t, obs(), expv());
         end
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL rstmid_done got=%0d exp=0", dones);
      end
   endtask

   task automatic test_random();
      logic e;
      for (int t = 0; t < 400; t++) begin
         e = ($urandom_range(0, 3) == 0);
         step(e);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL rand_t%0d got=%h exp=%h", t, obs(), expv());
         end
      end
   endtask

   task automatic test_lfsr();
      apply_reset();
      step(1'b1);
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL lfsr_first got=%b exp=0", bus.busy);
      end
      for (int t = 0; t < 300; t++) begin
         step(1'b1);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL lfsr_t%0d got=%h exp=%h", t, obs(), expv());
         end
      end
   endtask

   initial begin
      bus.en = 1'b0;
      test_reset();
`ifdef SPAWN_LFSR_EN
      test_lfsr();
`else
      test_single();
      test_held();
      test_ignore_en();
      test_reset_mid();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
